// File: rtl/gray_rx_pkg.sv
// Shared types and constants for the Gray-code receiver.
// Holds the tracker state enum, the per-sample step class and the largest
// supported lock threshold.
package gray_rx_pkg;

  // Tracker state.
  // IDLE: no reference value yet.
  // ACQ:  counting consecutive legal moves.
  // LOCK: the stream is trusted.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACQ  = 2'd1,
    LOCK = 2'd2
  } state_t;

  // Classification of one sample relative to the previous accepted value.
  typedef enum logic [1:0] {
    HOLD = 2'd0,
    FWD  = 2'd1,
    BWD  = 2'd2,
    ERR  = 2'd3
  } step_t;

  // Largest supported lock threshold.
  // The good-move counter is sized to hold this value.
  localparam int LOCK_N_MAX = 15;
  localparam int GOOD_W     = 4;

endpackage : gray_rx_pkg

// File: rtl/gray2bin.sv
// Purely combinational reflected-binary Gray to binary decoder.
// Each binary bit is the XOR of all Gray bits at or above its position.
// This is the closed form of bin[i] = bin[i+1] ^ g[i]. Using it keeps every
// output bit free of a dependency on the other output bits.
module gray2bin #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      // Prefix XOR from the MSB down to this bit position.
      assign o_bin[gi] = ^i_gray[W-1:gi];
    end
  endgenerate

endmodule : gray2bin

// File: rtl/gray_rx.sv
// Gray-code receiver and step tracker.
// Decodes each accepted Gray sample and classifies the move against the
// previous accepted value as hold, +1, -1 or illegal. A small FSM decides
// when the stream counts as locked. All outputs are registered, with one
// cycle of latency.
//
// Optional feature: define GRAY_RX_ERRCNT_EN to build the saturating
// illegal-move counter. Without that macro, err_cnt is tied to zero.
module gray_rx
  import gray_rx_pkg::*;
#(
  parameter int W      = 8,
  parameter int LOCK_N = 4,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     gray_in,
  output logic             out_valid,
  output logic [W-1:0]     bin_out,
  output logic             step_fwd,
  output logic             step_bwd,
  output logic             err,
  output logic             locked,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [W-1:0]      DELTA_FWD = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0]      DELTA_BWD = {W{1'b1}};
  localparam logic [GOOD_W-1:0] GOOD_ONE  = {{(GOOD_W-1){1'b0}}, 1'b1};

  // Decoded sample and the signed distance from the reference.
  logic [W-1:0]      w_bin;
  logic [W-1:0]      w_delta;
  step_t             w_step;

  // FSM and pulse next-state values.
  state_t            r_state;
  state_t            w_state_next;
  logic [GOOD_W-1:0] r_good;
  logic [GOOD_W-1:0] w_good_next;
  logic [GOOD_W-1:0] w_good_inc;
  logic              w_fwd_next;
  logic              w_bwd_next;
  logic              w_err_next;

  // Reference value and registered outputs.
  logic [W-1:0]      r_ref;
  logic [W-1:0]      r_bin_out;
  logic              r_out_valid;
  logic              r_step_fwd;
  logic              r_step_bwd;
  logic              r_err;
  logic              r_locked;

  gray2bin #(
    .W (W)
  ) u_gray2bin (
    .i_gray (gray_in),
    .o_bin  (w_bin)
  );

  // Classify the decoded sample by its modular distance from the reference.
  // The modular subtraction makes the wrap from all-ones to zero count as a
  // forward move, and the reverse wrap count as a backward move.
  always_comb begin
    w_delta = w_bin - r_ref;
    w_step  = ERR;
    if (w_delta == '0) begin
      w_step = HOLD;
    end else if (w_delta == DELTA_FWD) begin
      w_step = FWD;
    end else if (w_delta == DELTA_BWD) begin
      w_step = BWD;
    end
  end

  assign w_good_inc = r_good + GOOD_ONE;

  // Next-state, good-move counter and pulse decisions for an accepted sample.
  always_comb begin
    w_state_next = r_state;
    w_good_next  = r_good;
    w_fwd_next   = 1'b0;
    w_bwd_next   = 1'b0;
    w_err_next   = 1'b0;
    if (in_valid) begin
      case (r_state)
        IDLE: begin
          // First sample only establishes the reference.
          // Nothing exists to compare it against.
          w_state_next = ACQ;
          w_good_next  = '0;
        end
        ACQ: begin
          case (w_step)
            FWD, BWD: begin
              w_fwd_next = (w_step == FWD);
              w_bwd_next = (w_step == BWD);
              if (int'(w_good_inc) >= LOCK_N) begin
                w_state_next = LOCK;
                w_good_next  = '0;
              end else begin
                w_good_next = w_good_inc;
              end
            end
            ERR: begin
              w_err_next  = 1'b1;
              w_good_next = '0;
            end
            default: begin
              // A hold neither helps nor hurts the acquisition count.
            end
          endcase
        end
        LOCK: begin
          case (w_step)
            FWD:     w_fwd_next = 1'b1;
            BWD:     w_bwd_next = 1'b1;
            ERR: begin
              w_err_next   = 1'b1;
              w_state_next = ACQ;
              w_good_next  = '0;
            end
            default: begin
              // A hold keeps the lock.
            end
          endcase
        end
        default: begin
          w_state_next = IDLE;
          w_good_next  = '0;
        end
      endcase
    end
  end

  // State register, reference tracking and registered outputs.
  // A reset on the same edge as a sample discards that sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_good      <= '0;
      r_ref       <= '0;
      r_bin_out   <= '0;
      r_out_valid <= 1'b0;
      r_step_fwd  <= 1'b0;
      r_step_bwd  <= 1'b0;
      r_err       <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_good      <= w_good_next;
      r_out_valid <= in_valid;
      r_step_fwd  <= w_fwd_next;
      r_step_bwd  <= w_bwd_next;
      r_err       <= w_err_next;
      // locked follows the state being entered.
      // It therefore rises and falls alongside the triggering out_valid.
      r_locked    <= (w_state_next == LOCK);
      if (in_valid) begin
        // Erroneous samples also become the new reference.
        r_ref     <= w_bin;
        r_bin_out <= w_bin;
      end
    end
  end

`ifdef GRAY_RX_ERRCNT_EN
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};
  logic [ERR_W-1:0] r_err_cnt;

  // Saturating count of illegal moves.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else if (w_err_next && (r_err_cnt != {ERR_W{1'b1}})) begin
      r_err_cnt <= r_err_cnt + ERR_ONE;
    end
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = '0;
`endif

  assign out_valid = r_out_valid;
  assign bin_out   = r_bin_out;
  assign step_fwd  = r_step_fwd;
  assign step_bwd  = r_step_bwd;
  assign err       = r_err;
  assign locked    = r_locked;

endmodule : gray_rx

// File: tb/tb_gray_rx.sv
// Directed testbench for gray_rx (W=8, LOCK_N=4, ERR_W=8).
// Expected values are hand-computed. The expected err_cnt follows
// GRAY_RX_ERRCNT_EN.
module tb_gray_rx;

  localparam int W      = 8;
  localparam int LOCK_N = 4;
  localparam int ERR_W  = 8;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [W-1:0]     gray_in;
  logic             out_valid;
  logic [W-1:0]     bin_out;
  logic             step_fwd;
  logic             step_bwd;
  logic             err;
  logic             locked;
  logic [ERR_W-1:0] err_cnt;

  int n_tests;
  int n_fail;

  gray_rx #(
    .W      (W),
    .LOCK_N (LOCK_N),
    .ERR_W  (ERR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .gray_in   (gray_in),
    .out_valid (out_valid),
    .bin_out   (bin_out),
    .step_fwd  (step_fwd),
    .step_bwd  (step_bwd),
    .err       (err),
    .locked    (locked),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected counter value, given the number of illegal moves seen since reset.
  function automatic logic [31:0] exp_cnt(input int n);
`ifdef GRAY_RX_ERRCNT_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Present one sample at a falling edge.
  // After the next rising edge, check the results at the following falling edge.
  // Flags are packed as {out_valid, step_fwd, step_bwd, err, locked}.
  task automatic sample(input string tag, input logic [7:0] g, input logic [7:0] eb,
                        input logic [4:0] eflags, input int nerr);
    in_valid = 1'b1;
    gray_in  = g;
    @(negedge clk);
    in_valid = 1'b0;
    $display("[TB] %s gray=0x%02h bin=%0d flags(v,f,b,e,l)=%b err_cnt=%0d",
             tag, g, bin_out, {out_valid, step_fwd, step_bwd, err, locked}, err_cnt);
    check({tag, ".flags"}, 32'({out_valid, step_fwd, step_bwd, err, locked}), 32'(eflags));
    check({tag, ".bin"}, 32'(bin_out), 32'(eb));
    check({tag, ".cnt"}, 32'(err_cnt), exp_cnt(nerr));
  endtask

  // Hold reset for one edge, optionally with a sample present, then expect all-zero outputs.
  task automatic do_reset(input string tag, input logic v, input logic [7:0] g);
    rst      = 1'b1;
    in_valid = v;
    gray_in  = g;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    $display("[TB] %s reset in_valid=%0b", tag, v);
    check({tag, ".flags"}, 32'({out_valid, step_fwd, step_bwd, err, locked}), 32'd0);
    check({tag, ".bin"}, 32'(bin_out), 32'd0);
    check({tag, ".cnt"}, 32'(err_cnt), 32'd0);
  endtask

  // One cycle without a sample: pulses must be low, while bin_out and locked hold.
  task automatic idle(input string tag, input logic [7:0] eb, input logic el);
    in_valid = 1'b0;
    @(negedge clk);
    $display("[TB] %s idle bin=%0d locked=%0b", tag, bin_out, locked);
    check({tag, ".flags"}, 32'({out_valid, step_fwd, step_bwd, err, locked}), 32'({4'b0000, el}));
    check({tag, ".bin"}, 32'(bin_out), 32'(eb));
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    in_valid = 1'b0;
    gray_in  = '0;
    @(negedge clk);

    // Reset, then acquire with four forward moves.
    do_reset("rst0", 1'b0, 8'h00);
    sample("acq0", 8'h00, 8'd0, 5'b10000, 0);
    sample("acq1", 8'h01, 8'd1, 5'b11000, 0);
    sample("acq2", 8'h03, 8'd2, 5'b11000, 0);
    sample("acq3", 8'h02, 8'd3, 5'b11000, 0);
    sample("acq4", 8'h06, 8'd4, 5'b11001, 0);
    idle("idle0", 8'd4, 1'b1);

    // Backward move while locked.
    sample("lk5",  8'h07, 8'd5, 5'b11001, 0);
    sample("bwd4", 8'h06, 8'd4, 5'b10101, 0);

    // Lock near the top of the range, then wrap in both directions.
    do_reset("rst1", 1'b0, 8'h00);
    sample("top251", 8'h86, 8'd251, 5'b10000, 0);
    sample("top252", 8'h82, 8'd252, 5'b11000, 0);
    sample("top253", 8'h83, 8'd253, 5'b11000, 0);
    sample("top254", 8'h81, 8'd254, 5'b11000, 0);
    sample("top255", 8'h80, 8'd255, 5'b11001, 0);
    sample("wrapf",  8'h00, 8'd0,   5'b11001, 0);
    sample("wrapb",  8'h80, 8'd255, 5'b10101, 0);

    // Illegal Hamming-1 move while locked, then relock.
    sample("up0",   8'h00, 8'd0, 5'b11001, 0);
    sample("up1",   8'h01, 8'd1, 5'b11001, 0);
    sample("up2",   8'h03, 8'd2, 5'b11001, 0);
    sample("err5",  8'h07, 8'd5, 5'b10010, 1);
    sample("rl4",   8'h06, 8'd4, 5'b10100, 1);
    sample("rl5",   8'h07, 8'd5, 5'b11000, 1);
    sample("rl6",   8'h05, 8'd6, 5'b11000, 1);
    sample("rl7",   8'h04, 8'd7, 5'b11001, 1);
    sample("err0",  8'h00, 8'd0, 5'b10010, 2);
    idle("idle1", 8'd0, 1'b0);

    // Holds in ACQ must not change the good-move count.
    do_reset("rst2", 1'b0, 8'h00);
    sample("h1",  8'h01, 8'd1, 5'b10000, 0);
    sample("h2",  8'h03, 8'd2, 5'b11000, 0);
    sample("hh0", 8'h03, 8'd2, 5'b10000, 0);
    sample("hh1", 8'h03, 8'd2, 5'b10000, 0);
    sample("hh2", 8'h03, 8'd2, 5'b10000, 0);
    sample("h3",  8'h02, 8'd3, 5'b11000, 0);
    sample("h4",  8'h06, 8'd4, 5'b11000, 0);
    sample("h5",  8'h07, 8'd5, 5'b11001, 0);

    // Reset while locked, with a sample present. That sample must be discarded.
    do_reset("rst3", 1'b1, 8'h05);
    sample("post1", 8'h01, 8'd1, 5'b10000, 0);
    sample("post2", 8'h03, 8'd2, 5'b11000, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_gray_rx
